divider_8bit: RTL

- Sequential unsigned 8-bit restoring divider: the inverse companion of the team's add-shift multiplier.
- Produces Quotient = Dividend / Divisor and Remainder = Dividend mod Divisor.
- Uses one shift/subtract step per quotient bit, sequenced by an internal FSM with a bit counter.
- Sits beside the multiplier in the arithmetic unit and uses the same Run/Done-style operator handshake.

---
 rtl/divider_8bit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/divider_8bit.sv
// Sequential unsigned 8-bit restoring divider, one shift/subtract pair per bit.
// Run/Done operator handshake shared with the add-shift multiplier.
module divider_8bit (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic [7:0] Dividend,
    input  logic [7:0] Divisor,
    output logic [7:0] Quotient,
    output logic [7:0] Remainder,
    output logic       Busy,
    output logic       Done,
    output logic       DivZero
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_SUB   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [8:0] a;
    logic [7:0] q;
    logic [7:0] b;
    logic [2:0] count;
    logic [9:0] diff;
    logic [8:0] a_sub;
    logic [7:0] q_sub;

    assign diff  = {1'b0, a} - {2'b00, b};
    assign a_sub = diff[9] ? a : diff[8:0];
    assign q_sub = {q[7:1], ~diff[9]};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S_IDLE;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = Run ? S_LOAD : S_IDLE;
            end
            S_LOAD: begin
                Busy       = 1'b1;
                state_next = (Divisor == 8'd0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                Busy       = 1'b1;
                state_next = S_SUB;
            end
            S_SUB: begin
                Busy       = 1'b1;
                state_next = (count == 3'd7) ? S_DONE : S_SHIFT;
            end
            S_DONE: begin
                Done       = 1'b1;
                state_next = Run ? S_DONE : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a         <= '0;
            q         <= '0;
            b         <= '0;
            count     <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivZero   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                end
                S_LOAD: begin
                    a       <= '0;
                    q       <= Dividend;
                    b       <= Divisor;
                    count   <= '0;
                    DivZero <= 1'b0;
                    if (Divisor == 8'd0) begin
                        Quotient  <= 8'hFF;
                        Remainder <= Dividend;
                        DivZero   <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    {a, q} <= {a[7:0], q, 1'b0};
                end
                S_SUB: begin
                    a     <= a_sub;
                    q     <= q_sub;
                    count <= count + 3'd1;
                    if (count == 3'd7) begin
                        Quotient  <= q_sub;
                        Remainder <= a_sub[7:0];
                    end
                end
                default: begin
                    // Corrupted state: drop everything, FSM returns to Idle.
                    a         <= '0;
                    q         <= '0;
                    b         <= '0;
                    count     <= '0;
                    Quotient  <= '0;
                    Remainder <= '0;
                    DivZero   <= 1'b0;
                end
            endcase
        end
    end

endmodule
